serial_twos_negate: RTL and testbench
=====================================

# serial_twos_negate

Sequential counterpart to the ALU's conditional-invert stage. The 32-bit XOR bank only inverts an operand under a control bit; this block completes the operation by applying the +1 carry-in, so its output is `neg ? (~in + 1) : in`. It processes DIGIT bits per cycle through a registered carry chain and uses valid/ready handshakes on both sides. It sits between the ALU result path and consumers that need a negated or restored magnitude, such as the multiplier/divider sign fix-up, where a full-width adder is not wanted.

## Interface
- WIDTH, 32, operand width in bits; must be a multiple of DIGIT
- DIGIT, 4, bits processed per cycle; WIDTH/DIGIT gives the number of steps (8 by default)
- clock  in  1  single clock; all state updates on the rising edge
- resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  operand offered
- in_ready  out  1  block can accept an operand
- in_data  in  WIDTH  operand
- in_neg  in  1  1 = output the two's-complement negation; 0 = pass the operand through
- out_valid  out  1  result is available
- out_ready  in  1  consumer accepts the result
- out_data  out  WIDTH  result
- out_ovf  out  1  negation not representable: in_neg=1 and in_data = 1 followed by all zeros
- out_zero  out  1  out_data == 0

## Operation
- States:
  - IDLE: in_ready=1.
  - BUSY: in_ready=0, out_valid=0.
  - DONE: out_valid=1, in_ready=0.
- IDLE → BUSY when in_valid & in_ready. On that edge the block latches:
  - in_data into the operand shift register;
  - in_neg into neg_r;
  - carry ← in_neg;
  - step ← 0.
- BUSY, every cycle, for digit index k = step:
  - sum = (operand[DIGIT-1:0] ^ {DIGIT{neg_r}}) + carry, computed DIGIT+1 bits wide;
  - the low DIGIT bits of sum are shifted into the MSB end of the result register, and the result register shifts right by DIGIT;
  - carry ← sum[DIGIT];
  - the operand register shifts right by DIGIT;
  - step increments.
- BUSY → DONE on the cycle that processes step = WIDTH/DIGIT − 1.
- out_ovf = neg_r & (original operand == 1 followed by WIDTH−1 zeros). It is computed at the accept edge and registered.
- out_zero is derived from the completed result register.
- DONE holds out_data, out_ovf and out_zero stable until out_ready. DONE → IDLE when out_ready.
- The final carry out of the MSB digit is discarded (arithmetic is mod 2^WIDTH).
- in_neg=0 still takes the full WIDTH/DIGIT steps. Latency does not depend on the data.
- in_valid while BUSY/DONE is ignored. The producer must hold in_data until the handshake.

## Timing
- Reset (resetn=0, asynchronous):
  - state=IDLE;
  - in_ready=1, out_valid=0;
  - out_data=0, out_ovf=0, out_zero=0;
  - carry=0, step=0.
- Latency: if the accept edge is cycle 0, out_valid rises after edge WIDTH/DIGIT (cycle 8 by default).
- out_ready high on the first DONE cycle: the result is consumed on that edge. in_ready=1 on the next cycle, so throughput is one operand per WIDTH/DIGIT+2 cycles at best.
- out_ready low: DONE holds indefinitely and all outputs stay unchanged.
- resetn asserted mid-BUSY or mid-DONE: the operation is abandoned and all state returns to the reset values immediately. No partial result is ever presented.
- resetn deassertion is synchronized externally. The block only requires resetn to be released away from a clock edge.

## Structure
- Shared package `alu_pkg` holds:
  - the state encoding typedef (IDLE, BUSY, DONE);
  - localparam STEPS = WIDTH/DIGIT;
  - the step counter width, $clog2(STEPS).
- One sub-module is natural: `digit_negate_slice`. It is combinational and does DIGIT-wide XOR with neg, plus add-with-carry. It is instantiated once and reused each step.
- Everything else stays in one module: control FSM, shift registers, counter, flags.

## Test plan
- in_data=0x00000005, in_neg=0 → after 8 cycles: out_data=0x00000005, out_ovf=0, out_zero=0.
- in_data=0x00000001, in_neg=1 → out_data=0xFFFFFFFF; in_data=0xFFFFFFFF, in_neg=1 → out_data=0x00000001.
- in_data=0x00000000, in_neg=1 → the carry ripples through all 8 digits; out_data=0, out_zero=1, out_ovf=0.
- in_data=0x80000000, in_neg=1 → out_data=0x80000000, out_ovf=1. Also 0x7FFFFFFF, in_neg=1 → 0x80000001, out_ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → outputs stable and in_ready=0. Pulse in_valid during BUSY → ignored. Then release out_ready → IDLE next cycle.
- Assert resetn=0 at step 3 of 0x12345678, in_neg=1 → immediately out_valid=0, in_ready=1, out_data=0. The next operand completes correctly (0x12345678, in_neg=1 → 0xEDCBA988).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU helpers: FSM encoding and default sizing.
// The default step count and counter width follow from the 32-bit, 4-bit-digit configuration.
package alu_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DIGIT_DEF = 4;
  localparam int STEPS     = WIDTH_DEF / DIGIT_DEF;
  localparam int STEP_W    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/digit_negate_slice.sv
// One digit of conditional invert plus carry-in add; purely combinational.
// Chained across cycles by the caller through a registered carry.
module digit_negate_slice
  import alu_pkg::*;
#(
  parameter int DIGIT = DIGIT_DEF
) (
  input  logic [DIGIT-1:0] d_i,
  input  logic             neg_i,
  input  logic             carry_i,
  output logic [DIGIT-1:0] sum_o,
  output logic             carry_o
);

  logic [DIGIT:0] sum;

  assign sum = {1'b0, d_i ^ {DIGIT{neg_i}}} + {{DIGIT{1'b0}}, carry_i};
  assign {carry_o, sum_o} = sum;

endmodule

// File: rtl/serial_twos_negate.sv
// Digit-serial conditional two's-complement negate: result after WIDTH/DIGIT cycles of BUSY.
// One operand in flight; in_ready low while BUSY/DONE, and DONE holds until out_ready.
module serial_twos_negate
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIGIT = DIGIT_DEF
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NSTEP = WIDTH / DIGIT;
  localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(NSTEP - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;

  digit_negate_slice #(.DIGIT(DIGIT)) u_slice (
    .d_i     (op_q[DIGIT-1:0]),
    .neg_i   (neg_q),
    .carry_i (carry_q),
    .sum_o   (dig_sum),
    .carry_o (dig_cout)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    res_d     = res_q;
    neg_d     = neg_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    step_d    = step_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = BUSY;
          op_d    = in_data;
          neg_d   = in_neg;
          carry_d = in_neg;
          step_d  = '0;
          ovf_d   = in_neg & (in_data == MIN_NEG);
        end
      end
      BUSY: begin
        // Low digit first; after NSTEP shifts digit 0 lands at the LSB end.
        op_d    = op_q >> DIGIT;
        res_d   = {dig_sum, res_q[WIDTH-1:DIGIT]};
        carry_d = dig_cout;
        step_d  = step_q + CNT_W'(1);
        if (step_q == LAST) begin
          state_d = DONE;
          step_d  = '0;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      op_q    <= '0;
      res_q   <= '0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      res_q   <= res_d;
      neg_q   <= neg_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      step_q  <= step_d;
    end
  end

  // Result register is only exposed once complete, so partial digits never leak out.
  assign out_data = (state_q == DONE) ? res_q : '0;
  assign out_ovf  = (state_q == DONE) & ovf_q;
  assign out_zero = (state_q == DONE) & (res_q == '0);

endmodule

// File: tb/tb_serial_twos_negate.sv
// Bench for serial_twos_negate: directed vector table, corner sequences, random ops vs model.
module tb_serial_twos_negate;

  localparam int STEPS_TB = 8;

  logic        clock = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_neg;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        out_zero;

  int n_cmp = 0;
  int n_err = 0;

  serial_twos_negate #(.WIDTH(32), .DIGIT(4)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_neg    (in_neg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic        neg;
    logic [31:0] exp_data;
    logic        exp_ovf;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge with the block idle; returns at a negedge with the block idle again.
  task automatic run_op(input string nm, input logic [31:0] d, input logic ng,
                        input logic [31:0] ed, input logic eo, input logic ez,
                        input int hold, input bit pulse);
    int cyc;
    out_ready = 1'b0;
    in_data   = d;
    in_neg    = ng;
    in_valid  = 1'b1;
    check({nm, " ready_at_offer"}, 64'(in_ready), 64'd1);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    in_data  = $urandom;
    in_neg   = 1'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 64) begin
      if (pulse && cyc == 2) begin
        check({nm, " ready_busy"}, 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_data  = 32'hAAAA_5555;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clock);
      cyc++;
    end
    in_valid = 1'b0;
    check({nm, " out_valid"}, 64'(out_valid), 64'd1);
    check({nm, " latency"}, 64'(cyc), 64'(STEPS_TB));
    for (int h = 0; h < hold; h++) begin
      check({nm, " hold_valid"}, 64'(out_valid), 64'd1);
      check({nm, " hold_ready"}, 64'(in_ready), 64'd0);
      check({nm, " hold_data"}, 64'(out_data), 64'(ed));
      @(negedge clock);
    end
    check({nm, " data"}, 64'(out_data), 64'(ed));
    check({nm, " ovf"}, 64'(out_ovf), 64'(eo));
    check({nm, " zero"}, 64'(out_zero), 64'(ez));
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check({nm, " idle_after"}, {62'd0, in_ready, out_valid}, 64'b10);
  endtask

  initial begin
    logic [31:0] rd, ref_d;
    logic        rn;
    int          sel;

    vecs[0] = '{32'h0000_0005, 1'b0, 32'h0000_0005, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
    vecs[3] = '{32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b1};
    vecs[4] = '{32'h8000_0000, 1'b1, 32'h8000_0000, 1'b1, 1'b0};
    vecs[5] = '{32'h7FFF_FFFF, 1'b1, 32'h8000_0001, 1'b0, 1'b0};
    vecs[6] = '{32'h1234_5678, 1'b1, 32'hEDCB_A988, 1'b0, 1'b0};
    vecs[7] = '{32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b0};

    resetn = 1'b0; in_valid = 1'b0; in_data = '0; in_neg = 1'b0; out_ready = 1'b0;
    #12;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data", 64'(out_data), 64'd0);
    check("reset flags", {62'd0, out_ovf, out_zero}, 64'd0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].data, vecs[i].neg,
             vecs[i].exp_data, vecs[i].exp_ovf, vecs[i].exp_zero, 0, 1'b0);

    // Backpressure with an ignored in_valid pulse during BUSY.
    run_op("backpressure", 32'h0000_0003, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0, 5, 1'b1);

    // Reset in the middle of an operation.
    in_data = 32'h1234_5678; in_neg = 1'b1; in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #2 resetn = 1'b0;
    #1;
    check("midreset out_valid", 64'(out_valid), 64'd0);
    check("midreset in_ready", 64'(in_ready), 64'd1);
    check("midreset out_data", 64'(out_data), 64'd0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    run_op("after_reset", 32'h1234_5678, 1'b1, 32'hEDCB_A988, 1'b0, 1'b0, 0, 1'b0);

    for (int r = 0; r < 40; r++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0: rd = 32'h8000_0000;
        1: rd = 32'h0000_0000;
        2: rd = 32'hFFFF_FFFF;
        default: rd = $urandom;
      endcase
      rn    = 1'($urandom);
      ref_d = rn ? (32'd0 - rd) : rd;
      run_op($sformatf("rand%0d", r), rd, rn, ref_d,
             rn && (rd == 32'h8000_0000), ref_d == 32'd0,
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
